// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, branch flush, memory-wait
// freeze, same-cycle WB bypass into the ID operands and saturating bubble/flush
// performance counters.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_id,
  input  logic [XLEN-1:0]   pc_id,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic [4:0]        rd_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic [XLEN-1:0]   rs1_data_id,
  input  logic [XLEN-1:0]   rs2_data_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              regwen_id,
  input  logic              memread_id,
  input  logic              memwen_id,
  input  logic [4:0]        rd_wb,
  input  logic              regwen_wb,
  input  logic [XLEN-1:0]   wdata_wb,
  input  logic              branch_taken_ex,
  input  logic              mem_wait,
  output logic              stall_if,
  output logic              flush_if_id,
  output logic              valid_ex,
  output logic [XLEN-1:0]   pc_ex,
  output logic [4:0]        rs1_ex,
  output logic [4:0]        rs2_ex,
  output logic [4:0]        rd_ex,
  output logic [XLEN-1:0]   rs1_data_ex,
  output logic [XLEN-1:0]   rs2_data_ex,
  output logic [XLEN-1:0]   imm_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              regwen_ex,
  output logic              memread_ex,
  output logic              memwen_ex,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FROZEN} state_e;

  state_e            r_state, w_state_nxt;
  logic              r_valid, r_regwen, r_memread, r_memwen;
  logic [XLEN-1:0]   r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]        r_rs1, r_rs2, r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_bubble_cnt, r_flush_cnt;

  logic w_hazard, w_load_use, w_flush, w_load_id, w_bubble;
  logic w_byp_rs1, w_byp_rs2;

  // Hazard detection, action priority (freeze > flush > load-use > run) and next state.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = ST_RUN;
    w_hazard    = r_valid & r_memread & (r_rd != 5'd0) & valid_id &
                  ((use_rs1_id & (rs1_id == r_rd)) | (use_rs2_id & (rs2_id == r_rd)));
    // The bubble inserted on entering STALL already clears the hazard; the
    // state gate just makes the one-cycle STALL explicit.
    w_load_use  = ~mem_wait & ~branch_taken_ex & w_hazard & (r_state != ST_STALL);
    w_flush     = ~mem_wait & branch_taken_ex;
    w_bubble    = w_flush | w_load_use;
    w_load_id   = ~mem_wait & ~w_bubble;
    stall_if    = mem_wait | w_load_use;
    flush_if_id = w_flush;
    if (mem_wait)        w_state_nxt = ST_FROZEN;
    else if (w_load_use) w_state_nxt = ST_STALL;
    w_byp_rs1   = regwen_wb & (rd_wb != 5'd0) & (rd_wb == rs1_id);
    w_byp_rs2   = regwen_wb & (rd_wb != 5'd0) & (rd_wb == rs2_id);
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // EX register bundle: load from ID, load a bubble, or hold while frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_ctrl     <= '0;
      r_regwen   <= 1'b0;
      r_memread  <= 1'b0;
      r_memwen   <= 1'b0;
    end else if (w_load_id) begin
      r_valid    <= valid_id;
      r_pc       <= pc_id;
      r_rs1      <= rs1_id;
      r_rs2      <= rs2_id;
      r_rd       <= rd_id;
      r_rs1_data <= w_byp_rs1 ? wdata_wb : rs1_data_id;
      r_rs2_data <= w_byp_rs2 ? wdata_wb : rs2_data_id;
      r_imm      <= imm_id;
      r_ctrl     <= ctrl_id;
      // x0 is never marked as written, so forwarding can never match it.
      r_regwen   <= regwen_id & valid_id & (rd_id != 5'd0);
      r_memread  <= memread_id;
      r_memwen   <= memwen_id;
    end else if (w_bubble) begin
      // Only the fields that carry side effects are cleared; the rest are don't-care.
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_regwen   <= 1'b0;
      r_memread  <= 1'b0;
      r_memwen   <= 1'b0;
    end
  end

  // Saturating performance counters; they hold during a freeze by construction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_load_use && !(&r_bubble_cnt)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (w_flush && !(&r_flush_cnt))     r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign valid_ex    = r_valid;
  assign pc_ex       = r_pc;
  assign rs1_ex      = r_rs1;
  assign rs2_ex      = r_rs2;
  assign rd_ex       = r_rd;
  assign rs1_data_ex = r_rs1_data;
  assign rs2_data_ex = r_rs2_data;
  assign imm_ex      = r_imm;
  assign ctrl_ex     = r_ctrl;
  assign regwen_ex   = r_regwen;
  assign memread_ex  = r_memread;
  assign memwen_ex   = r_memwen;
  assign bubble_cnt  = r_bubble_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: interlock, x0 rule, flush priority, freeze,
// WB bypass, counter saturation and asynchronous reset mid-stall.
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 4;  // small so saturation is reachable in a few cycles

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid_id, use_rs1_id, use_rs2_id, regwen_id, memread_id, memwen_id;
  logic [XLEN-1:0]   pc_id, rs1_data_id, rs2_data_id, imm_id, wdata_wb;
  logic [4:0]        rs1_id, rs2_id, rd_id, rd_wb;
  logic [CTRL_W-1:0] ctrl_id;
  logic              regwen_wb, branch_taken_ex, mem_wait;
  logic              stall_if, flush_if_id, valid_ex, regwen_ex, memread_ex, memwen_ex;
  logic [XLEN-1:0]   pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]        rs1_ex, rs2_ex, rd_ex;
  logic [CTRL_W-1:0] ctrl_ex;
  logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid_id(valid_id), .pc_id(pc_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .ctrl_id(ctrl_id), .regwen_id(regwen_id), .memread_id(memread_id),
    .memwen_id(memwen_id), .rd_wb(rd_wb), .regwen_wb(regwen_wb), .wdata_wb(wdata_wb),
    .branch_taken_ex(branch_taken_ex), .mem_wait(mem_wait),
    .stall_if(stall_if), .flush_if_id(flush_if_id), .valid_ex(valid_ex),
    .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .ctrl_ex(ctrl_ex), .regwen_ex(regwen_ex), .memread_ex(memread_ex),
    .memwen_ex(memwen_ex), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an ID instruction; operand data and ctrl derive from the fields.
  task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic u1, input logic u2,
                        input logic rw, input logic mr, input logic mw);
    valid_id    = v;
    pc_id       = pc;
    rd_id       = rd;
    rs1_id      = s1;
    rs2_id      = s2;
    use_rs1_id  = u1;
    use_rs2_id  = u2;
    regwen_id   = rw;
    memread_id  = mr;
    memwen_id   = mw;
    rs1_data_id = 32'h1000 + 32'(s1);
    rs2_data_id = 32'h2000 + 32'(s2);
    imm_id      = pc + 32'd4;
    ctrl_id     = 12'(rd) | 12'h100;
  endtask

  initial begin
    reset_n = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_wb = 0; regwen_wb = 0; wdata_wb = 0; branch_taken_ex = 0; mem_wait = 0;
    #8;
    // Reset state
    check("rst_valid_ex", valid_ex, 0);
    check("rst_pc_ex", pc_ex, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_stall_if", stall_if, 0);
    #4 reset_n = 1'b1;
    tick();

    // Load-use: lw x5 then add x6,x5,x7
    id_set(1, 32'h10, 5, 1, 0, 1, 0, 1, 1, 0);
    tick();
    check("lw_valid_ex", valid_ex, 1);
    check("lw_memread_ex", memread_ex, 1);
    check("lw_rd_ex", rd_ex, 5);
    check("lw_regwen_ex", regwen_ex, 1);
    id_set(1, 32'h14, 6, 5, 7, 1, 1, 1, 0, 0);
    #1;
    check("lu_stall_if", stall_if, 1);
    check("lu_flush_if_id", flush_if_id, 0);
    tick();
    check("lu_bubble_valid", valid_ex, 0);
    check("lu_bubble_regwen", regwen_ex, 0);
    check("lu_bubble_ctrl", ctrl_ex, 0);
    check("lu_bubble_cnt", bubble_cnt, 1);
    check("lu_stall_cleared", stall_if, 0);
    tick();
    check("add_valid_ex", valid_ex, 1);
    check("add_rd_ex", rd_ex, 6);
    check("add_pc_ex", pc_ex, 32'h14);
    check("add_bubble_cnt", bubble_cnt, 1);

    // x0: load to x0 never interlocks and never marks a write
    id_set(1, 32'h18, 0, 0, 0, 1, 0, 1, 1, 0);
    tick();
    check("lwx0_regwen_ex", regwen_ex, 0);
    check("lwx0_memread_ex", memread_ex, 1);
    id_set(1, 32'h1c, 0, 0, 0, 1, 1, 1, 0, 0);
    #1;
    check("x0_no_stall", stall_if, 0);
    tick();
    check("addx0_valid_ex", valid_ex, 1);
    check("addx0_regwen_ex", regwen_ex, 0);
    check("addx0_pc_ex", pc_ex, 32'h1c);

    // Branch in the same cycle as a load-use: flush wins
    id_set(1, 32'h20, 5, 1, 0, 1, 0, 1, 1, 0);
    tick();
    id_set(1, 32'h24, 6, 5, 7, 1, 1, 1, 0, 0);
    branch_taken_ex = 1;
    #1;
    check("br_lu_flush_if_id", flush_if_id, 1);
    check("br_lu_stall_if", stall_if, 0);
    tick();
    branch_taken_ex = 0;
    check("br_lu_valid_ex", valid_ex, 0);
    check("br_lu_memread_ex", memread_ex, 0);
    check("br_lu_flush_cnt", flush_cnt, 1);
    check("br_lu_bubble_cnt", bubble_cnt, 1);

    // Freeze for 3 cycles with a pending branch, flush taken on cycle 4
    id_set(1, 32'h100, 8, 1, 2, 1, 1, 1, 0, 0);
    tick();
    check("pre_frz_rd_ex", rd_ex, 8);
    id_set(1, 32'h104, 9, 8, 8, 1, 1, 1, 0, 0);
    mem_wait = 1;
    branch_taken_ex = 1;
    #1;
    check("frz_stall_if", stall_if, 1);
    check("frz_flush_if_id", flush_if_id, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_valid_ex", valid_ex, 1);
      check("frz_rd_ex", rd_ex, 8);
      check("frz_pc_ex", pc_ex, 32'h100);
      check("frz_flush_cnt", flush_cnt, 1);
    end
    mem_wait = 0;
    #1;
    check("unfrz_flush_if_id", flush_if_id, 1);
    check("unfrz_stall_if", stall_if, 0);
    tick();
    branch_taken_ex = 0;
    check("unfrz_valid_ex", valid_ex, 0);
    check("unfrz_flush_cnt", flush_cnt, 2);

    // WB bypass into ID operands
    id_set(1, 32'h200, 10, 3, 9, 1, 1, 1, 0, 0);
    rs1_data_id = 32'h1111;
    rs2_data_id = 32'h2222;
    rd_wb = 9; regwen_wb = 1; wdata_wb = 32'hDEADBEEF;
    tick();
    check("byp_rs2_data_ex", rs2_data_ex, 32'hDEADBEEF);
    check("byp_rs1_data_ex", rs1_data_ex, 32'h1111);
    check("byp_imm_ex", imm_ex, 32'h204);
    check("byp_ctrl_ex", ctrl_ex, 12'h10A);
    id_set(1, 32'h204, 11, 0, 9, 1, 1, 1, 0, 1);
    rs1_data_id = 32'h5555;
    rs2_data_id = 32'h6666;
    rd_wb = 0;
    tick();
    regwen_wb = 0;
    check("nobyp_x0_rs1", rs1_data_ex, 32'h5555);
    check("nobyp_rs2", rs2_data_ex, 32'h6666);
    check("st_memwen_ex", memwen_ex, 1);

    // Bubble counter saturation: 1 + 16 load-uses -> clamps at all ones
    for (int i = 0; i < 16; i++) begin
      id_set(1, 32'h300, 5, 1, 0, 1, 0, 1, 1, 0);
      tick();
      id_set(1, 32'h304, 6, 5, 7, 1, 1, 1, 0, 0);
      tick();
      tick();
    end
    check("sat_bubble_cnt", bubble_cnt, 4'hF);
    id_set(1, 32'h308, 5, 1, 0, 1, 0, 1, 1, 0);
    tick();
    id_set(1, 32'h30c, 6, 5, 7, 1, 1, 1, 0, 0);
    #1;
    check("sat_lu_stall_if", stall_if, 1);
    tick();
    check("sat_lu_valid_ex", valid_ex, 0);
    check("sat_bubble_hold", bubble_cnt, 4'hF);
    tick();

    // Flush counter: 2 + 12 -> 14, then 3 more -> clamps at all ones
    branch_taken_ex = 1;
    repeat (12) tick();
    check("flush_cnt_14", flush_cnt, 4'hE);
    repeat (3) tick();
    check("sat_flush_cnt", flush_cnt, 4'hF);
    branch_taken_ex = 0;

    // Asynchronous reset in the middle of a load-use stall
    id_set(1, 32'h400, 5, 1, 0, 1, 0, 1, 1, 0);
    tick();
    id_set(1, 32'h404, 6, 5, 7, 1, 1, 1, 0, 0);
    #1;
    check("prerst_stall_if", stall_if, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid_ex", valid_ex, 0);
    check("midrst_pc_ex", pc_ex, 0);
    check("midrst_rd_ex", rd_ex, 0);
    check("midrst_memread_ex", memread_ex, 0);
    check("midrst_bubble_cnt", bubble_cnt, 0);
    check("midrst_flush_cnt", flush_cnt, 0);
    check("midrst_stall_if", stall_if, 0);
    #2 reset_n = 1'b1;
    tick();
    check("postrst_valid_ex", valid_ex, 1);
    check("postrst_rd_ex", rd_ex, 6);
    check("postrst_bubble_cnt", bubble_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
